// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types for the UART receive controller.
// Holds the receive FSM state encoding.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_CHK = 2'd1,
    RECV      = 2'd2,
    CHECK     = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-period timer plus received-bit counter.
// Ports: clk, n_rst (async, active-high), clear_i, enable_i,
//        half_tick_o, full_tick_o, bit_cnt_o.
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT),
  parameter int BC_W         = $clog2(DATA_BITS + 2)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear_i,
  input  logic            enable_i,
  output logic            half_tick_o,
  output logic            full_tick_o,
  output logic [BC_W-1:0] bit_cnt_o
);

  localparam logic [CNT_W-1:0] HALF_M1 =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 =
    CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BC_W-1:0]  bc_q, bc_d;

  assign half_tick_o = enable_i && (cnt_q == HALF_M1);
  assign full_tick_o = enable_i && (cnt_q == FULL_M1);
  assign bit_cnt_o   = bc_q;

  always_comb begin
    cnt_d = cnt_q;
    bc_d  = bc_q;
    if (clear_i) begin
      cnt_d = '0;
      bc_d  = '0;
    end else if (enable_i) begin
      if (cnt_q == FULL_M1) begin
        cnt_d = '0;
        bc_d  = bc_q + BC_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      cnt_q <= '0;
      bc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      bc_q  <= bc_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive control - start detect, mid-bit strobes,
// stop check, word buffer. Ports: clk, n_rst (async, active-high),
// serial_in, sr_data, data_read -> shift_strobe, rx_data,
// data_ready, framing_error, overrun_error.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic [DATA_BITS:0]   sr_data,
  input  logic                 data_read,
  output logic                 shift_strobe,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BC_W  = $clog2(DATA_BITS + 2);

  logic sync1_q, sync2_q, prev_q;
  logic line, fall;

  rx_state_t state_q, state_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic dr_q, dr_d;
  logic fe_q, fe_d;
  logic ov_q, ov_d;

  logic            tmr_clr, tmr_en;
  logic            half_tick, full_tick;
  logic [BC_W-1:0] bit_cnt;

  assign line = sync2_q;
  assign fall = prev_q & ~sync2_q;

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .CNT_W        (CNT_W),
    .BC_W         (BC_W)
  ) u_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear_i     (tmr_clr),
    .enable_i    (tmr_en),
    .half_tick_o (half_tick),
    .full_tick_o (full_tick),
    .bit_cnt_o   (bit_cnt)
  );

  always_comb begin
    state_d      = state_q;
    rx_d         = rx_q;
    dr_d         = dr_q;
    fe_d         = fe_q;
    ov_d         = ov_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    shift_strobe = 1'b0;

    if (data_read && dr_q) begin
      dr_d = 1'b0;
      ov_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // hold the timer at zero so START_CHK begins from 0
        tmr_clr = 1'b1;
        if (fall) begin
          state_d = START_CHK;
          fe_d    = 1'b0;
        end
      end
      START_CHK: begin
        tmr_en = 1'b1;
        if (half_tick) begin
          tmr_clr = 1'b1;
          state_d = line ? IDLE : RECV;
        end
      end
      RECV: begin
        tmr_en = 1'b1;
        if (full_tick) begin
          shift_strobe = 1'b1;
          // bit_cnt still holds the pre-increment value here
          if (bit_cnt == BC_W'(DATA_BITS))
            state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (sr_data[DATA_BITS]) begin
          // a coincident data_read loses to the new word
          rx_d = sr_data[DATA_BITS-1:0];
          dr_d = 1'b1;
          if (dr_q && !data_read)
            ov_d = 1'b1;
        end else begin
          fe_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      rx_q    <= '0;
      dr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      rx_q    <= rx_d;
      dr_q    <= dr_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign rx_data       = rx_q;
  assign data_ready    = dr_q;
  assign framing_error = fe_q;
  assign overrun_error = ov_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl.
// Models the line synchronizer and the 9-bit shift register.
module tb_uart_rx_ctrl;

  localparam int DB  = 8;
  localparam int CPB = 10;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          serial_in = 1'b1;
  logic          data_read = 1'b0;
  logic [DB:0]   sr_data = '0;
  logic          shift_strobe;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic          framing_error;
  logic          overrun_error;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_BITS    (DB),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .sr_data       (sr_data),
    .data_read     (data_read),
    .shift_strobe  (shift_strobe),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_cyc = 0;
  int strb_tot = 0;
  int strb_base = 0;

  logic [10:0] exp_q[$];
  logic [10:0] prev_obs = '0;
  logic        m1 = 1'b1;
  logic        m2 = 1'b1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      m1 <= 1'b1;
      m2 <= 1'b1;
    end else begin
      m1 <= serial_in;
      m2 <= m1;
    end
  end

  always @(posedge clk)
    if (shift_strobe) sr_data <= {m2, sr_data[DB:1]};

  // strobe position: start driven at c0, strobe n lands at c0+17+10(n-1)
  always @(negedge clk) begin
    if (shift_strobe) begin
      strb_tot = strb_tot + 1;
      chk("strobe_pos", cyc - start_cyc,
          17 + CPB * (strb_tot - strb_base - 1));
    end
  end

  always @(negedge clk) begin
    logic [10:0] cur;
    cur = {rx_data, data_ready, framing_error, overrun_error};
    if (cur !== prev_obs) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got %0h expected no change",
                 cur);
      end else begin
        chk("sb_out", cur, exp_q.pop_front());
      end
      prev_obs = cur;
    end
  end

  task automatic push(input logic [7:0] d, input logic r,
                      input logic f, input logic o);
    exp_q.push_back({d, r, f, o});
  endtask

  task automatic send(input logic [7:0] d, input logic stop,
                      input int gap);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    strb_base = strb_tot;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      serial_in = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    serial_in = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic wait_strb(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while ((strb_tot - strb_base) < n && k < 300);
    if ((strb_tot - strb_base) < n) begin
      n_chk++;
      $display("FAIL wait_strobe: got %0d expected %0d",
               strb_tot - strb_base, n);
    end
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    @(posedge clk);
    #1;
    data_read = 1'b0;
  endtask

  initial begin
    #1 n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx", rx_data, 0);
    chk("rst_dr", data_ready, 0);
    chk("rst_fe", framing_error, 0);
    chk("rst_ov", overrun_error, 0);
    chk("rst_strobe", shift_strobe, 0);
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 1: good frame
    push(8'hA5, 1, 0, 0);
    send(8'hA5, 1'b1, 3);
    chk("t1_strobes", strb_tot - strb_base, 9);
    chk("t1_rx", rx_data, 8'hA5);
    chk("t1_dr", data_ready, 1);
    chk("t1_err", {framing_error, overrun_error}, 0);
    push(8'hA5, 0, 0, 0);
    read_pulse();
    repeat (2) @(posedge clk);
    #1;

    // 2: false start
    strb_base = strb_tot;
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("t2_strobes", strb_tot - strb_base, 0);
    chk("t2_rx", rx_data, 8'hA5);
    chk("t2_dr", data_ready, 0);

    // 3: bad stop bit
    push(8'hA5, 0, 1, 0);
    send(8'h3C, 1'b0, 3);
    chk("t3_strobes", strb_tot - strb_base, 9);
    chk("t3_fe", framing_error, 1);
    chk("t3_rx", rx_data, 8'hA5);

    // 4: overrun, back-to-back frames
    push(8'hA5, 0, 0, 0);
    push(8'h11, 1, 0, 0);
    send(8'h11, 1'b1, 0);
    push(8'h22, 1, 0, 1);
    send(8'h22, 1'b1, 3);
    chk("t4_rx", rx_data, 8'h22);
    chk("t4_ov", overrun_error, 1);
    push(8'h22, 0, 0, 0);
    read_pulse();
    #1;
    chk("t4_clr", {data_ready, overrun_error}, 0);

    // 5: read coincides with load
    push(8'h44, 1, 0, 0);
    send(8'h44, 1'b1, 3);
    push(8'h55, 1, 0, 0);
    fork
      send(8'h55, 1'b1, 3);
      begin
        wait_strb(9);
        @(posedge clk);
        #1;
        read_pulse();
      end
    join
    chk("t5_dr", data_ready, 1);
    chk("t5_ov", overrun_error, 0);

    // 6: reset after the 4th strobe; rest of frame stays high
    push(8'h00, 0, 0, 0);
    fork
      send(8'hFB, 1'b1, 3);
      begin
        wait_strb(4);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        chk("t6_rst_out",
            {rx_data, data_ready, framing_error, overrun_error}, 0);
        chk("t6_rst_strobe", shift_strobe, 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;
      end
    join
    chk("t6_strobes", strb_tot - strb_base, 4);
    push(8'h0F, 1, 0, 0);
    send(8'h0F, 1'b1, 3);
    chk("t6_strobes2", strb_tot - strb_base, 9);
    chk("t6_rx", rx_data, 8'h0F);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
